// File: rtl/ptp_rx_ts_capture.sv
// ptp_rx_ts_capture
// Snoops the MAC receive byte stream, samples the free-running time counter
// on the first byte of each frame, and parses Ethernet (optionally one
// 802.1Q tag) for EtherType 0x88F7. For accepted PTP messages the tuple
// {frame-start time, messageType, sequenceId} is queued in a small
// first-word-fall-through FIFO.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   data, enable       received byte, qualified by enable (low between frames)
//   counter_val        free-running time counter
//   ts_rd              pop the head entry (ignored while ts_valid=0)
//   ts_valid           FIFO non-empty
//   ts_time/ts_msg_type/ts_seq_id  registered head entry fields
//   fifo_level         number of entries held
//   overflow_count     events dropped on a full FIFO, saturating
module ptp_rx_ts_capture #(
   parameter int          COUNTER_WIDTH  = 64,
   parameter int          FIFO_DEPTH     = 4,
   parameter int          PREAMBLE_BYTES = 8,
   parameter int          ENABLE_VLAN    = 1,
   parameter logic [15:0] MSG_TYPE_MASK  = 16'h000F
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     data,
   input  logic                           enable,
   input  logic [COUNTER_WIDTH-1:0]       counter_val,
   input  logic                           ts_rd,
   output logic                           ts_valid,
   output logic [COUNTER_WIDTH-1:0]       ts_time,
   output logic [3:0]                     ts_msg_type,
   output logic [15:0]                    ts_seq_id,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic [15:0]                    overflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = COUNTER_WIDTH + 20;

   // Byte offsets within the frame (index 0 = first enable cycle).
   localparam logic [6:0] E_IDX   = 7'(PREAMBLE_BYTES + 12);
   localparam logic [6:0] H_UNTAG = 7'(PREAMBLE_BYTES + 14);
   localparam logic [6:0] H_TAG   = 7'(PREAMBLE_BYTES + 18);

   typedef enum logic [2:0] {
      WAIT_GAP = 3'd0,
      IDLE     = 3'd1,
      ETH      = 3'd2,
      PTP      = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [6:0]               idx_q, idx_d;
   logic [COUNTER_WIDTH-1:0] t_sof_q, t_sof_d;
   logic                     tagged_q, tagged_d;
   logic [7:0]               type_hi_q, type_hi_d;
   logic [3:0]               msg_q, msg_d;
   logic [7:0]               seq_hi_q, seq_hi_d;
   logic                     push_req_s;

   logic [EW-1:0]            mem_q [FIFO_DEPTH];
   logic [EW-1:0]            mem_d [FIFO_DEPTH];
   logic [LW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]            head_q, head_d;
   logic                     valid_q, valid_d;
   logic [LW-1:0]            level_q, level_d;
   logic [15:0]              ovf_q, ovf_d;

   logic [6:0]               eth_hi_idx_s, h_idx_s, idx_inc_s;
   logic [15:0]              type_s;
   logic                     full_s, empty_s, pop_s, do_push_s, drop_s;
   logic [EW-1:0]            entry_s;

   // Frame parser: next state, byte index and captured header fields.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      t_sof_d    = t_sof_q;
      tagged_d   = tagged_q;
      type_hi_d  = type_hi_q;
      msg_d      = msg_q;
      seq_hi_d   = seq_hi_q;
      push_req_s = 1'b0;

      // After a tag the EtherType moves back by four bytes.
      eth_hi_idx_s = tagged_q ? (E_IDX + 7'd4) : E_IDX;
      h_idx_s      = tagged_q ? H_TAG : H_UNTAG;
      idx_inc_s    = (idx_q == 7'd127) ? idx_q : (idx_q + 7'd1);
      type_s       = {type_hi_q, data};

      case (state_q)
         WAIT_GAP: begin
            // A frame already in flight at reset release is never parsed.
            if (!enable) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_GAP;
            end
         end
         IDLE: begin
            if (enable) begin
               t_sof_d  = counter_val;
               idx_d    = 7'd1;
               tagged_d = 1'b0;
               state_d  = ETH;
            end else begin
               state_d = IDLE;
            end
         end
         ETH: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_inc_s;
               if (idx_q == eth_hi_idx_s) begin
                  type_hi_d = data;
               end else if (idx_q == eth_hi_idx_s + 7'd1) begin
                  if (type_s == 16'h8100 && ENABLE_VLAN != 0 && !tagged_q) begin
                     tagged_d = 1'b1;
                  end else if (type_s == 16'h88F7) begin
                     state_d = PTP;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  state_d = ETH;
               end
            end
         end
         PTP: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_inc_s;
               if (idx_q == h_idx_s) begin
                  msg_d = data[3:0];
               end else if (idx_q == h_idx_s + 7'd30) begin
                  seq_hi_d = data;
               end else if (idx_q == h_idx_s + 7'd31) begin
                  push_req_s = MSG_TYPE_MASK[msg_q];
                  state_d    = DONE;
               end else begin
                  state_d = PTP;
               end
            end
         end
         DONE: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = WAIT_GAP;
         end
      endcase
   end

   // Parser state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WAIT_GAP;
         idx_q     <= 7'd0;
         t_sof_q   <= '0;
         tagged_q  <= 1'b0;
         type_hi_q <= 8'd0;
         msg_q     <= 4'd0;
         seq_hi_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         t_sof_q   <= t_sof_d;
         tagged_q  <= tagged_d;
         type_hi_q <= type_hi_d;
         msg_q     <= msg_d;
         seq_hi_q  <= seq_hi_d;
      end
   end

   assign entry_s   = {t_sof_q, msg_q, seq_hi_q, data};
   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_s     = ts_rd && !empty_s;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push_s = push_req_s && (!full_s || pop_s);
   assign drop_s    = push_req_s && full_s && !pop_s;

   // FIFO next state; head fields are re-registered from the post-update array.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q[AW-1:0]] = entry_s;
         wr_ptr_d                = wr_ptr_q + LW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + LW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (drop_s && ovf_q != 16'hFFFF) begin
         ovf_d = ovf_q + 16'd1;
      end else begin
         ovf_d = ovf_q;
      end
      head_d  = mem_d[rd_ptr_d[AW-1:0]];
      level_d = wr_ptr_d - rd_ptr_d;
      valid_d = (wr_ptr_d != rd_ptr_d);
   end

   // FIFO storage, pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         level_q  <= '0;
         ovf_q    <= 16'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ts_valid       = valid_q;
   assign ts_time        = head_q[EW-1 -: COUNTER_WIDTH];
   assign ts_msg_type    = head_q[19:16];
   assign ts_seq_id      = head_q[15:0];
   assign fifo_level     = level_q;
   assign overflow_count = ovf_q;

endmodule
